// File: rtl/serial_stream_addsub_pkg.sv
// Shared types and default sizing for the serial add/sub stream block.
package serial_stream_pkg;

   localparam int LANES_DEF    = 4;
   localparam int WORD_LEN_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/serial_stream_addsub_if.sv
// Bit-serial operand/result bundle: master drives operands, slave returns results.
interface serial_stream_addsub_if
   import serial_stream_pkg::*;
#(
   parameter int LANES = LANES_DEF
) ();

   logic             clr;
   logic             in_valid;
   logic             sub;
   logic [LANES-1:0] a;
   logic [LANES-1:0] b;
   logic             sum_valid;
   logic [LANES-1:0] sum;
   logic             word_done;
   logic [LANES-1:0] carry_out;
   logic [LANES-1:0] ovf;

   modport master (
      output clr, in_valid, sub, a, b,
      input  sum_valid, sum, word_done, carry_out, ovf
   );

   modport slave (
      input  clr, in_valid, sub, a, b,
      output sum_valid, sum, word_done, carry_out, ovf
   );

endinterface

// File: rtl/serial_stream_addsub_lane.sv
// One bit-serial full-adder lane: running carry, optional B inversion for
// subtract, registered result bit and end-of-word carry/overflow flags.
module serial_fa_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic fire_i,
   input  logic first_i,
   input  logic last_i,
   input  logic mode_i,
   input  logic a_i,
   input  logic b_i,
   output logic sum_o,
   output logic cout_o,
   output logic ovf_o
);

   logic c_q;
   logic sum_q;
   logic cout_q;
   logic ovf_q;
   logic c_in;
   logic b_eff;
   logic s_bit;
   logic c_nxt;

   // Bit 0 takes its carry-in from the mode (the +1 of two's-complement subtract).
   always_comb begin
      c_in  = first_i ? mode_i : c_q;
      b_eff = b_i ^ mode_i;
      s_bit = a_i ^ b_eff ^ c_in;
      c_nxt = (a_i & b_eff) | (a_i & c_in) | (b_eff & c_in);
   end

   // Carry chain, result bit and MSB flags; clr drops the carry but keeps the flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q    <= 1'b0;
         sum_q  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (clr_i) begin
         c_q <= 1'b0;
      end else if (fire_i) begin
         c_q   <= c_nxt;
         sum_q <= s_bit;
         if (last_i) begin
            cout_q <= c_nxt;
            ovf_q  <= c_in ^ c_nxt;
         end
      end
   end

   assign sum_o  = sum_q;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/serial_stream_addsub.sv
// Multi-lane LSB-first serial adder/subtractor with shared bit counter and FSM.
//
// state | meaning
// IDLE  | no word in progress, bit counter 0; next valid bit is bit 0
// BUSY  | word in progress, counter holds index of the next bit
module serial_stream_addsub
   import serial_stream_pkg::*;
#(
   parameter int LANES    = LANES_DEF,
   parameter int WORD_LEN = WORD_LEN_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   serial_stream_addsub_if.slave bus
);

   localparam int            CW       = $clog2(WORD_LEN);
   localparam logic [CW-1:0] LAST_IDX = CW'(WORD_LEN - 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            mode_q, mode_d;
   logic            sum_valid_q, sum_valid_d;
   logic            word_done_q, word_done_d;

   logic            fire;
   logic            first;
   logic            last;
   logic            mode_eff;
   logic [LANES-1:0] sum_bits;
   logic [LANES-1:0] cout_bits;
   logic [LANES-1:0] ovf_bits;

   // clr overrides in_valid, so a bit presented alongside clr is dropped.
   always_comb begin
      fire     = bus.in_valid & ~bus.clr;
      first    = (state_q == IDLE);
      last     = (state_q == BUSY) && (cnt_q == LAST_IDX);
      mode_eff = first ? bus.sub : mode_q;
   end

   // Next-state, counter, mode latch and registered strobes.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      mode_d      = mode_q;
      sum_valid_d = fire;
      word_done_d = fire & last;
      if (bus.clr) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (bus.in_valid) begin
         unique case (state_q)
            IDLE: begin
               mode_d  = bus.sub;
               cnt_d   = CW'(1);
               state_d = BUSY;
            end
            BUSY: begin
               if (last) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mode_q      <= 1'b0;
         sum_valid_q <= 1'b0;
         word_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mode_q      <= mode_d;
         sum_valid_q <= sum_valid_d;
         word_done_q <= word_done_d;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      serial_fa_lane u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .clr_i   (bus.clr),
         .fire_i  (fire),
         .first_i (first),
         .last_i  (last),
         .mode_i  (mode_eff),
         .a_i     (bus.a[g]),
         .b_i     (bus.b[g]),
         .sum_o   (sum_bits[g]),
         .cout_o  (cout_bits[g]),
         .ovf_o   (ovf_bits[g])
      );
   end

   assign bus.sum       = sum_bits;
   assign bus.sum_valid = sum_valid_q;
   assign bus.word_done = word_done_q;
   assign bus.carry_out = cout_bits;
   assign bus.ovf       = ovf_bits;

endmodule

// File: tb/tb_serial_stream_addsub.sv
// Scoreboard bench for serial_stream_addsub with LANES=2, WORD_LEN=4.
module tb_serial_stream_addsub;

   localparam int LANES = 2;
   localparam int WL    = 4;

   typedef struct packed {
      logic [1:0] s;
      logic       wd;
      logic [1:0] co;
      logic [1:0] ov;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   exp_t sb[$];
   exp_t e;
   int   wd_cyc[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   wd_seen = 0;
   int   cyc     = 0;

   always #5 clk = ~clk;

   serial_stream_addsub_if #(.LANES(LANES)) bus ();

   serial_stream_addsub #(.LANES(LANES), .WORD_LEN(WL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: every presented result bit is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.word_done) begin
            wd_seen++;
            wd_cyc.push_back(cyc);
         end
         if (bus.sum_valid) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_sum_valid: got sum_valid=1 with no bit pending, required 0");
            end else begin
               e = sb.pop_front();
               check("sum", 32'(bus.sum), 32'(e.s));
               check("word_done", 32'(bus.word_done), 32'(e.wd));
               if (e.wd) begin
                  check("carry_out", 32'(bus.carry_out), 32'(e.co));
                  check("ovf", 32'(bus.ovf), 32'(e.ov));
               end
            end
         end else if (bus.word_done) begin
            n_tests++;
            n_fail++;
            $display("FAIL word_done_without_valid: got word_done=1, required 0");
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b0;
         bus.clr      = 1'b0;
      end
   endtask

   // Issues one word bit by bit; gap_at inserts 3 idle cycles before that bit,
   // clr_at asserts clr together with that bit and abandons the word.
   task automatic send_word(input logic [1:0][3:0] aw, input logic [1:0][3:0] bw,
                            input logic sub_v, input bit tog, input int gap_at,
                            input int clr_at, input logic [1:0][3:0] sw,
                            input logic [1:0] co, input logic [1:0] ov);
      for (int i = 0; i < WL; i++) begin
         if (i == gap_at) idle(3);
         @(posedge clk);
         #1;
         bus.in_valid = 1'b1;
         bus.a        = {aw[1][i], aw[0][i]};
         bus.b        = {bw[1][i], bw[0][i]};
         bus.sub      = (tog && (i % 2 == 1)) ? ~sub_v : sub_v;
         if (i == clr_at) begin
            bus.clr = 1'b1;
            @(posedge clk);
            #1;
            bus.clr      = 1'b0;
            bus.in_valid = 1'b0;
            return;
         end
         sb.push_back('{s: {sw[1][i], sw[0][i]}, wd: (i == WL - 1), co: co, ov: ov});
      end
   endtask

   // lane1 7+9=16 (carry, no ovf), lane0 5+3=8 (ovf, no carry)
   localparam logic [1:0][3:0] ADD_A = {4'd7, 4'd5};
   localparam logic [1:0][3:0] ADD_B = {4'd9, 4'd3};
   localparam logic [1:0][3:0] ADD_S = {4'd0, 4'd8};
   // lane1 7-9=-2 (ovf, borrow), lane0 3-5=-2 (borrow, no ovf)
   localparam logic [1:0][3:0] SUB_A = {4'd7, 4'd3};
   localparam logic [1:0][3:0] SUB_B = {4'd9, 4'd5};
   localparam logic [1:0][3:0] SUB_S = {4'd14, 4'd14};

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.clr      = 1'b0;
      bus.in_valid = 1'b0;
      bus.sub      = 1'b0;
      bus.a        = '0;
      bus.b        = '0;
      #12;
      check("rst_sum", 32'(bus.sum), 32'd0);
      check("rst_sum_valid", 32'(bus.sum_valid), 32'd0);
      check("rst_word_done", 32'(bus.word_done), 32'd0);
      check("rst_carry_out", 32'(bus.carry_out), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);

      send_word(ADD_A, ADD_B, 1'b0, 1'b0, -1, -1, ADD_S, 2'b10, 2'b01);
      idle(2);
      send_word(SUB_A, SUB_B, 1'b1, 1'b1, -1, -1, SUB_S, 2'b00, 2'b10);
      idle(2);
      send_word(ADD_A, ADD_B, 1'b0, 1'b0, 2, -1, ADD_S, 2'b10, 2'b01);
      idle(2);

      send_word(ADD_A, ADD_B, 1'b0, 1'b0, -1, 2, ADD_S, 2'b10, 2'b01);
      idle(1);
      check("clr_keeps_carry_out", 32'(bus.carry_out), 32'h2);
      check("clr_keeps_ovf", 32'(bus.ovf), 32'h1);
      send_word(ADD_A, ADD_B, 1'b0, 1'b0, -1, -1, ADD_S, 2'b10, 2'b01);
      idle(2);

      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         bus.in_valid = 1'b1;
         bus.sub      = 1'b0;
         bus.a        = {ADD_A[1][i], ADD_A[0][i]};
         bus.b        = {ADD_B[1][i], ADD_B[0][i]};
         sb.push_back('{s: {ADD_S[1][i], ADD_S[0][i]}, wd: 1'b0, co: 2'b10, ov: 2'b01});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_sum", 32'(bus.sum), 32'd0);
      check("mid_rst_sum_valid", 32'(bus.sum_valid), 32'd0);
      check("mid_rst_word_done", 32'(bus.word_done), 32'd0);
      check("mid_rst_carry_out", 32'(bus.carry_out), 32'd0);
      check("mid_rst_ovf", 32'(bus.ovf), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_word(SUB_A, SUB_B, 1'b1, 1'b0, -1, -1, SUB_S, 2'b00, 2'b10);
      idle(2);

      send_word(ADD_A, ADD_B, 1'b0, 1'b0, -1, -1, ADD_S, 2'b10, 2'b01);
      send_word(SUB_A, SUB_B, 1'b1, 1'b1, -1, -1, SUB_S, 2'b00, 2'b10);
      idle(4);

      check("queue_drained", 32'(sb.size()), 32'd0);
      check("word_done_count", 32'(wd_seen), 32'd7);
      if (wd_cyc.size() >= 2)
         check("b2b_spacing", 32'(wd_cyc[wd_cyc.size()-1] - wd_cyc[wd_cyc.size()-2]), 32'd4);
      else
         check("b2b_spacing_count", 32'(wd_cyc.size()), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_stream_addsub.md
SERIAL_STREAM_ADDSUB -- requirements
Module: serial_stream_addsub

Interface
REQ-001 The block SHALL have parameter LANES, default 4, giving the number of independent serial adder channels (1..32).
REQ-002 The block SHALL have parameter WORD_LEN, default 8, giving the bits per word (2..64).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous abort of the word in progress.
REQ-006 The block SHALL have port in_valid, input, 1 bit: a, b and sub carry one bit position this cycle.
REQ-007 The block SHALL have port sub, input, 1 bit: 0 selects A+B and 1 selects A-B; sampled on the first bit of a word only.
REQ-008 The block SHALL have port a, input, LANES bits: operand A bits, LSB-first, one bit per lane.
REQ-009 The block SHALL have port b, input, LANES bits: operand B bits, LSB-first, one bit per lane.
REQ-010 The block SHALL have port sum_valid, output, 1 bit: sum holds a valid result bit.
REQ-011 The block SHALL have port sum, output, LANES bits: result bits, LSB-first.
REQ-012 The block SHALL have port word_done, output, 1 bit: one-cycle pulse coincident with the MSB result bit.
REQ-013 The block SHALL have port carry_out, output, LANES bits: unsigned carry out per lane (for subtract, 1 means no borrow); valid while word_done is high, held otherwise.
REQ-014 The block SHALL have port ovf, output, LANES bits: signed two's-complement overflow per lane; valid while word_done is high, held otherwise.

Function
REQ-015 The FSM SHALL have two states. IDLE: no word in progress, bit counter 0. BUSY: a word is in progress.
REQ-016 In IDLE with in_valid=1, the block SHALL latch sub into mode_q, use carry-in = sub for every lane, process bit 0, and go to BUSY (or stay in IDLE if WORD_LEN were 1, which is excluded).
REQ-017 Per lane, the block SHALL use b_eff = b XOR mode, sum = a XOR b_eff XOR c, and c_next = majority(a, b_eff, c).
REQ-018 In BUSY with in_valid=1, the block SHALL increment the bit counter; on the bit with counter = WORD_LEN-1, it SHALL process the MSB, wrap the counter to 0 and return to IDLE.
REQ-019 When in_valid=0, the block SHALL hold counter, carries and mode; gaps of any length are legal mid-word.
REQ-020 Outputs SHALL be registered with latency 1: the input bit at cycle t gives sum/sum_valid at t+1; sum_valid=0 on the cycle after in_valid=0.
REQ-021 sum SHALL hold its last value when sum_valid=0.
REQ-022 On the MSB bit, carry_out SHALL be loaded with the carry out of the MSB and ovf with (carry into MSB) XOR (carry out of MSB); word_done SHALL pulse with that MSB's sum_valid.
REQ-023 Changes of sub after bit 0 SHALL have no effect on the word in progress.
REQ-024 clr=1 SHALL force IDLE, counter 0 and carries 0 next cycle, and SHALL suppress sum_valid and word_done next cycle.
REQ-025 If clr and in_valid are both 1, clr SHALL win and the bit SHALL be discarded.
REQ-026 clr SHALL leave carry_out and ovf unchanged.
REQ-027 Back-to-back words SHALL be supported: the bit after an MSB is bit 0 of the next word, with a fresh carry-in and mode sample.

Reset
REQ-028 While rst_n=0, the block SHALL immediately force state IDLE, counter 0, carries 0, mode_q 0, and sum, sum_valid, word_done, carry_out and ovf all 0.
REQ-029 Reset asserted mid-word SHALL discard that word; the first valid bit after reset release SHALL be bit 0.

Structure
REQ-030 Package serial_stream_pkg SHALL hold the FSM state enum (IDLE, BUSY) and default constants for LANES and WORD_LEN.
REQ-031 Sub-module serial_fa_lane (one carry register, b inversion, sum/carry logic, carry-into-MSB capture) SHALL be instantiated LANES times by generate.
REQ-032 The counter SHALL be $clog2(WORD_LEN) bits wide; control and FSM SHALL be shared across lanes.

Verification (LANES=2, WORD_LEN=4)
REQ-033 Scenario add: lane0 5+3 (a=1,0,1,0; b=1,1,0,0), lane1 7+9, sub=0 -> lane0 sum 0,0,0,1, carry_out 0, ovf 1; lane1 sum 0,0,0,0, carry_out 1, ovf 0; word_done once, on the 4th sum_valid.
REQ-034 Scenario subtract: lane0 3-5, sub=1 -> sum 0,1,1,1 (=-2), carry_out 0, ovf 0; toggling sub during bits 1..3 changes nothing.
REQ-035 Scenario gaps: same stimulus as REQ-033 with in_valid low 3 cycles between bits 1 and 2 -> identical results, sum_valid low during the gaps.
REQ-036 Scenario clr: clr with in_valid on bit 2 of a word, then a fresh 5+3 word -> no word_done for the aborted word; the fresh word matches REQ-033.
REQ-037 Scenario reset: rst_n low mid-word -> all outputs 0 immediately; a post-reset word behaves as bit 0.
REQ-038 Scenario back-to-back: 5+3 then 3-5 with continuous in_valid -> word_done pulses 4 cycles apart, results as in REQ-033 and REQ-034.
